fir_decim_sequencer: RTL and testbench

Control sequencer for the decimating FIR filter built around the 1024 x 18-bit coefficient ROM. It writes incoming samples into a circular sample buffer. Every DECIM-th sample it runs one full multiply-accumulate pass: it walks the coefficient ROM and sample buffer addresses in lockstep, and drives the clear, enable and dump controls of an external MAC. It sits between the CIC/decimator output strobe and the MAC/output register of each FIR channel; one instance per channel.

---
 rtl/fir_decim_sequencer.sv | 71 +++++++
 tb/tb_fir_decim_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fir_decim_sequencer.sv
// fir_decim_sequencer: decimating FIR control (clock/reset, x_strobe in; sample RAM wr/rd, coef ROM addr, MAC clr/en, y_strobe, busy, overrun out)
module fir_decim_sequencer #(
  parameter int ADDR_W = 10,
  parameter int NTAPS  = 1024,
  parameter int DECIM  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_strobe,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [ADDR_W:0]   rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              y_strobe,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DUMP} state_t;
  localparam logic [7:0] PMAX = 8'(DECIM - 1);
  localparam logic [7:0] DMAX = 8'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] KMAX = ADDR_W'(NTAPS - 1);
  state_t state, state_n;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W-1:0] k;
  logic [7:0] phase, dcnt;
  logic [RD_LAT-1:0] en_d, clr_d;
  logic trig;
  assign trig = x_strobe && phase == PMAX;
  assign wr_en = x_strobe && !reset;
  assign wr_addr = wr_ptr;
  assign coef_addr = k;
  assign mac_en = en_d[RD_LAT-1];
  assign mac_clr = clr_d[RD_LAT-1];
  always_comb begin
    state_n = state == IDLE  ? (trig ? RUN : IDLE) :
              state == RUN   ? (k == KMAX ? DRAIN : RUN) :
              state == DRAIN ? (dcnt == DMAX ? DUMP : DRAIN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      phase    <= '0;
      k        <= '0;
      dcnt     <= '0;
      rd_addr  <= '0;
      en_d     <= '0;
      clr_d    <= '0;
      busy     <= 1'b0;
      y_strobe <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= state_n != IDLE;
      y_strobe <= state_n == DUMP;
      overrun  <= overrun || (trig && state != IDLE);
      if (x_strobe) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= phase == PMAX ? '0 : phase + 1'b1;
      end
      k       <= state == RUN ? k + 1'b1 : '0;
      dcnt    <= state == DRAIN ? dcnt + 1'b1 : '0;
      rd_addr <= state == RUN ? rd_addr - 1'b1 : (state == IDLE && trig) ? wr_ptr : rd_addr;
      en_d    <= RD_LAT'({en_d, state == RUN});
      clr_d   <= RD_LAT'({clr_d, state == RUN && k == '0});
    end
  end
endmodule

// File: tb/tb_fir_decim_sequencer.sv
// tb_fir_decim_sequencer: self-checking bench with per-cycle reference model, vector table and corner sequences
module tb_fir_decim_sequencer;
  localparam int NT = 1024;
  localparam int L = 1;
  localparam int PASS = NT + L + 1;
  logic clock = 0, reset = 1, x_strobe = 0;
  logic wr_en, mac_clr, mac_en, y_strobe, busy, overrun;
  logic [10:0] wr_addr, rd_addr;
  logic [9:0] coef_addr;
  fir_decim_sequencer dut (
    .clock(clock), .reset(reset), .x_strobe(x_strobe), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .y_strobe(y_strobe), .busy(busy), .overrun(overrun)
  );
  always #5 clock = ~clock;
  int cyc = 0, tests = 0, fails = 0, ycnt = 0;
  int m_wr = 0, m_ph = 0, m_base = 0, pass_t = -1, off;
  bit m_ov = 0;
  logic [5:0] e_v, a_v;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    off = pass_t < 0 ? -1 : cyc - pass_t;
    if (reset) begin
      m_wr = 0; m_ph = 0; m_ov = 0; pass_t = -1;
    end else begin
      e_v = {x_strobe, off >= 1 && off <= PASS, off >= 1 + L && off <= NT + L, off == 1 + L, off == PASS, m_ov};
      a_v = {wr_en, busy, mac_en, mac_clr, y_strobe, overrun};
      check("ctrl{wr_en,busy,mac_en,mac_clr,y,ovr}", a_v, e_v);
      check("wr_addr", wr_addr, m_wr);
      if (off >= 1 && off <= NT) begin
        check("coef_addr", coef_addr, off - 1);
        check("rd_addr", rd_addr, (m_base - (off - 1) + 2048) % 2048);
      end
      if (y_strobe) ycnt++;
      if (x_strobe) begin
        if (m_ph == 7) begin
          if (off >= 1 && off <= PASS) m_ov = 1;
          else begin pass_t = cyc; m_base = m_wr; end
        end
        m_wr = (m_wr + 1) % 2048;
        m_ph = (m_ph + 1) % 8;
      end
    end
  end
  task automatic strobe();
    x_strobe = 1;
    @(posedge clock); #1 x_strobe = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic rst();
    reset = 1;
    @(posedge clock); #1 reset = 0;
  endtask
  task automatic fill(int n, int p);
    repeat (n) begin strobe(); idle(p - 1); end
  endtask
  typedef struct {int period; int n; int exp_y; bit exp_ov;} vec_t;
  vec_t tbl[3];
  int t, nen, nclr, nbusy, yoff, clroff;
  initial begin
    tbl[0] = '{200, 8, 1, 0};
    tbl[1] = '{129, 24, 3, 0};
    tbl[2] = '{100, 16, 1, 1};
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check("reset_outputs", {wr_en, wr_addr, rd_addr, coef_addr, mac_clr, mac_en, y_strobe, busy, overrun}, 0);
    @(posedge clock); #1;
    rst(); fill(7, 200); t = cyc; strobe();
    nen = 0; nclr = 0; nbusy = 0; yoff = -1; clroff = -1;
    for (int o = 1; o <= 1100; o++) begin
      @(negedge clock);
      if (o == 1) begin check("first_coef", coef_addr, 0); check("first_rd", rd_addr, 7); end
      if (o == 9) check("k8_rd", rd_addr, 2047);
      if (o == 1024) begin check("last_coef", coef_addr, 1023); check("last_rd", rd_addr, 1032); end
      nen += int'(mac_en);
      nbusy += int'(busy);
      if (mac_clr) begin nclr++; clroff = o; end
      if (y_strobe) yoff = o;
    end
    check("mac_en_count", nen, 1024);
    check("mac_clr_count", nclr, 1);
    check("mac_clr_offset", clroff, 2);
    check("busy_length", nbusy, 1026);
    check("y_offset", yoff, 1026);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      rst(); ycnt = 0;
      fill(tbl[i].n, tbl[i].period);
      idle(1100);
      check($sformatf("vec%0d_ycount", i), ycnt, tbl[i].exp_y);
      check($sformatf("vec%0d_overrun", i), overrun, tbl[i].exp_ov);
    end
    rst(); fill(7, 200); t = cyc; strobe(); idle(500);
    check("k500_coef", coef_addr, 500);
    rst();
    @(negedge clock);
    check("abort_outputs", {wr_en, wr_addr, rd_addr, coef_addr, mac_clr, mac_en, y_strobe, busy, overrun}, 0);
    @(posedge clock); #1;
    fill(7, 200); strobe();
    @(negedge clock);
    check("restart_rd", rd_addr, 7);
    check("restart_busy", busy, 1);
    @(posedge clock); #1;
    idle(1100);
    rst(); fill(7, 200); t = cyc; strobe(); idle(99);
    fill(7, 100);
    idle(226);
    check("dump_align", cyc - t, 1026);
    strobe();
    @(negedge clock);
    check("dump_trig_busy", busy, 0);
    check("dump_trig_overrun", overrun, 1);
    @(posedge clock); #1;
    idle(20);
    check("dump_no_restart", busy, 0);
    rst(); fill(2100, 2); idle(1100);
    check("wrap_wr_addr", wr_addr, 2100 % 2048);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
